// File: rtl/lcv_mul_acc_pipe.sv
// Three-stage signed multiply-accumulate engine with LOAD/CLEAR/MSU ops,
// optional saturation, sticky overflow and valid/ready flow control.
module lcv_mul_acc_pipe #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int ACC_WIDTH = 40,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        inp_valid,
    output logic                        inp_ready,
    input  logic signed [A_WIDTH-1:0]   inp_a,
    input  logic signed [B_WIDTH-1:0]   inp_b,
    input  logic signed [ACC_WIDTH-1:0] inp_c,
    input  logic [1:0]                  inp_op,
    input  logic                        inp_last,
    output logic                        outp_valid,
    input  logic                        outp_ready,
    output logic signed [ACC_WIDTH-1:0] outp_data,
    output logic                        outp_last,
    output logic                        outp_ovf,
    output logic                        outp_ovf_sticky
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int N_WIDTH = ACC_WIDTH + 2;

    typedef enum logic [1:0] {
        OP_MAC   = 2'd0,
        OP_MSU   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    if (ACC_WIDTH < P_WIDTH) begin : g_width_check
        $error("lcv_mul_acc_pipe: ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
    end

    logic                        en;
    logic                        s1_valid, s1_last;
    logic signed [A_WIDTH-1:0]   s1_a;
    logic signed [B_WIDTH-1:0]   s1_b;
    logic signed [ACC_WIDTH-1:0] s1_c;
    op_e                         s1_op;

    logic                        s2_valid, s2_last;
    logic signed [N_WIDTH-1:0]   s2_t;
    op_e                         s2_op;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [P_WIDTH-1:0]   prod;
    logic signed [N_WIDTH-1:0]   t_next, acc_ext, n;
    logic [2:0]                  n_top;
    logic                        ovf, sticky_next;
    logic signed [ACC_WIDTH-1:0] result;

    // One enable freezes the whole pipe, so a stalled beat is never lost or duplicated.
    assign en        = !outp_valid || outp_ready;
    assign inp_ready = en;

    // The accumulator is the output register; keeping it only in stage 3 lets
    // back-to-back beats chain without bubbles.
    assign outp_data = acc;

    assign prod    = s1_a * s1_b;
    assign t_next  = {{(N_WIDTH-P_WIDTH){prod[P_WIDTH-1]}}, prod}
                   + {{2{s1_c[ACC_WIDTH-1]}}, s1_c};
    assign acc_ext = {{2{acc[ACC_WIDTH-1]}}, acc};

    always_comb begin
        // NOTE: default first so every path assigns n; otherwise a latch is inferred.
        n = '0;
        case (s2_op)
            OP_MAC:   n = acc_ext + s2_t;
            OP_MSU:   n = acc_ext - s2_t;
            OP_LOAD:  n = s2_t;
            OP_CLEAR: n = '0;
            default:  n = '0;
        endcase
    end

    // n fits in ACC_WIDTH bits only when its top three bits are all equal.
    assign n_top = n[N_WIDTH-1:ACC_WIDTH-1];
    assign ovf   = !((n_top == 3'b000) || (n_top == 3'b111));

    always_comb begin
        result = n[ACC_WIDTH-1:0];
        if (ovf && SATURATE) begin
            result = n[N_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        sticky_next = outp_ovf_sticky | ovf;
        case (s2_op)
            OP_LOAD:  sticky_next = ovf;
            OP_CLEAR: sticky_next = 1'b0;
            default:  sticky_next = outp_ovf_sticky | ovf;
        endcase
    end

    // NOTE: non-blocking assignments so every stage samples the pre-edge value of the one before.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid        <= 1'b0;
            s1_last         <= 1'b0;
            s1_a            <= '0;
            s1_b            <= '0;
            s1_c            <= '0;
            s1_op           <= OP_MAC;
            s2_valid        <= 1'b0;
            s2_last         <= 1'b0;
            s2_t            <= '0;
            s2_op           <= OP_MAC;
            acc             <= '0;
            outp_valid      <= 1'b0;
            outp_last       <= 1'b0;
            outp_ovf        <= 1'b0;
            outp_ovf_sticky <= 1'b0;
        end else if (en) begin
            s1_valid   <= inp_valid;
            s1_last    <= inp_last;
            s1_a       <= inp_a;
            s1_b       <= inp_b;
            s1_c       <= inp_c;
            s1_op      <= op_e'(inp_op);

            s2_valid   <= s1_valid;
            s2_last    <= s1_last;
            s2_t       <= t_next;
            s2_op      <= s1_op;

            outp_valid <= s2_valid;
            if (s2_valid) begin
                acc             <= result;
                outp_ovf        <= ovf;
                outp_last       <= s2_last;
                outp_ovf_sticky <= sticky_next;
            end
        end
    end

endmodule

// File: doc/lcv_mul_acc_pipe.md
Name: lcv_mul_acc_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate engine; successor to the fixed 16x16/33-bit MAC blocks.
- Adds configurable operand/accumulator widths, an internal accumulator with four ops, optional saturation, sticky overflow, and valid/ready flow control with full-pipeline stall.
- Sits between operand-fetch logic and a result consumer (filter taps, dot products); written so synthesis maps the multiply/add onto DSP slices.

Parameters:
- A_WIDTH, 16, signed multiplicand width.
- B_WIDTH, 16, signed multiplier width.
- ACC_WIDTH, 40, accumulator, addend and result width; must be >= A_WIDTH+B_WIDTH (elaboration error otherwise).
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- inp_valid  in  1  operand beat valid.
- inp_ready  out  1  engine can accept a beat.
- inp_a  in  A_WIDTH  signed multiplicand.
- inp_b  in  B_WIDTH  signed multiplier.
- inp_c  in  ACC_WIDTH  signed addend.
- inp_op  in  2  0=MAC, 1=MSU, 2=LOAD, 3=CLEAR.
- inp_last  in  1  tag carried to output unchanged.
- outp_valid  out  1  result valid.
- outp_ready  in  1  consumer accepts result.
- outp_data  out  ACC_WIDTH  accumulator value after this beat.
- outp_last  out  1  inp_last of this beat.
- outp_ovf  out  1  this beat overflowed.
- outp_ovf_sticky  out  1  any overflow since last LOAD/CLEAR.

Behaviour:
- Interface: clk is the single clock. rst is asynchronous, active-high, and is the only reset.
- Reset: all stage valids=0, accumulator=0, outp_data=0, outp_valid=0, outp_last=0, outp_ovf=0, outp_ovf_sticky=0. A reset asserted mid-operation discards all in-flight beats. inp_ready=1 once rst deasserts.
- Enable: en = !outp_valid || outp_ready. inp_ready = en, combinational. A beat is accepted when inp_valid && inp_ready.
- When en=0: every pipeline stage, the accumulator and all outputs hold. No beat is lost or duplicated.
- Stage 1 (reg): capture a, b, c, op, last, and valid = accepted.
- Stage 2 (reg): p = a*b, sign-extended to ACC_WIDTH+2. t = p + sext(c) in ACC_WIDTH+2 bits. Forward op, last, valid.
- Stage 3 (reg): compute n in ACC_WIDTH+2 bits:
  - MAC: n = acc + t.
  - MSU: n = acc - t.
  - LOAD: n = t.
  - CLEAR: n = 0 (a, b, c ignored).
- Overflow: ovf = n outside [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - SATURATE=1: result = MAX or MIN matching the sign of n.
  - SATURATE=0: result = n[ACC_WIDTH-1:0].
- Stage 3 update: acc <= result. outp_data <= result. outp_ovf <= ovf. outp_last <= last. outp_valid <= stage-2 valid.
- Sticky overflow:
  - LOAD: sticky <= ovf.
  - CLEAR: sticky <= 0.
  - MAC/MSU: sticky <= sticky | ovf.
- Latency: exactly 3 clk edges from acceptance to outp_valid when unstalled. Throughput is 1 beat/cycle.
- Back-to-back beats see each other's accumulator update with no bubbles, because the accumulator lives only in stage 3.
- Invalid stage-2 slots (bubbles) leave acc and sticky unchanged. outp_valid drops to 0 on the next enabled edge.
- Simultaneous outp_ready && new acceptance with the pipe full: the pipe advances and throughput is preserved.
- inp_c uses the full ACC_WIDTH, so LOAD can preset any accumulator value.

Test Plan:
- Reset, then LOAD a=3,b=4,c=5 -> after 3 cycles outp_valid=1, outp_data=17, ovf=0. Follow with MAC a=-2,b=6,c=0 on the next cycle -> next cycle outp_data=5.
- Stream LOAD(a=1,b=1,c=0) then MAC(a=2,b=2,c=1) x4, outp_ready=1 -> outputs 1,6,11,16,21 on consecutive cycles. inp_ready stays 1 throughout. outp_last matches the input tags.
- Same stream with outp_ready=0 for 5 cycles mid-stream -> inp_ready=0 while outp_valid=1. outp_data holds. On release the sequence resumes intact with no loss or duplication.
- ACC_WIDTH=32, SATURATE=1: LOAD(a=0,b=0,c=0x7FFFFFFF), then MAC(a=1,b=1,c=0) -> outp_data=0x7FFFFFFF, outp_ovf=1, sticky=1. MSU(a=1,b=1,c=0) -> 0x7FFFFFFE, ovf=0, sticky=1. CLEAR -> data=0, sticky=0.
- ACC_WIDTH=32, SATURATE=0: same first two beats -> outp_data=0x80000000, outp_ovf=1.
- Accept 3 beats, assert rst asynchronously mid-cycle for 1 cycle -> outputs immediately 0, no result ever emitted for those beats. The next LOAD(a=2,b=2,c=0) returns 4 after 3 cycles.
